ffs: RTL and testbench
======================

// Module: ffs
// PURPOSE
//  Multi-cycle modular subtractor over GF(p), p = 2^255 - 19. Inverse counterpart of the field adder.
//  Computes out = (a_i - b_i) mod p with one 64-bit limb subtractor and one 64-bit limb adder.
//  The adder path is pipelined one limb behind the subtractor path.
//  Used by the point add/double datapath wherever a field difference is needed.
// PARAMETERS
//  W      255               operand/result width (fixed; only default supported)
//  LIMB   64                limb width; operands zero-extended to 256b = 4 limbs
//  P      2^255-19 (256b)   field modulus
// PORTS
//  clk    in   1    clock, all state on rising edge
//  rst    in   1    asynchronous, active-high reset
//  start  in   1    request; sampled only in IDLE
//  a_i    in   255  minuend, required < p; captured on the accepting edge
//  b_i    in   255  subtrahend, required < p; captured on the accepting edge
//  out    out  255  registered result; held until the next operation's completion edge
//  busy   out  1    high from the accepting edge until the completion edge
//  done   out  1    one-cycle registered completion pulse
// BEHAVIOUR
//  Reset:
//   - Asynchronous, active-high: state=IDLE, out=0, done=0, busy=0, internal regs/borrow/carry=0.
//  Limb data:
//   - A = {1'b0,a_i} and B = {1'b0,b_i} are captured; limb k = bits [64k+63:64k].
//  FSM: IDLE -> L0 -> L1 -> L2 -> L3 -> FIX -> IDLE.
//   - Each state lasts exactly one cycle; there is no stall.
//  IDLE:
//   - done <= 0.
//   - If start=1: capture A and B, busy <= 1, go to L0 (edge E0).
//   - If start=0: stay in IDLE; a_i/b_i are don't-care.
//  Subtract path (L0..L3 = edges E1..E4):
//   - At edge E(k+1): D[k] <= A[k] - B[k] - bo, where bo <= borrow out.
//   - bo = 0 for limb 0.
//  Correct path (L1..FIX = edges E2..E5), one limb behind:
//   - At edge E(k+2): S[k] <= D[k] + P[k] + c, where c <= carry out.
//   - c = 0 for limb 0.
//   - Carry out of limb 3 is discarded (mod 2^256).
//  FIX (edge E5):
//   - If final subtract borrow bo3 = 1 (a < b): out <= S[254:0] (limb 3 taken from the current adder output).
//   - If bo3 = 0: out <= D[254:0].
//   - done <= 1, busy <= 0, go to IDLE.
//  Latency and throughput:
//   - done is high in the cycle after E5, i.e. 5 edges after the accepting edge.
//   - start is ignored while busy. In the done cycle the FSM is IDLE, so a start there is accepted (back-to-back, 6-cycle throughput).
//  Arithmetic:
//   - For a,b < p the result is always in [0, p-1].
//   - a = b gives 0.
//   - Result bit 255 is 0 by construction and is dropped.
//   - Out-of-range inputs (>= p) give low 255 bits of (a - b + (a<b ? p : 0)); result not guaranteed reduced.
//  Input stability:
//   - Changing a_i/b_i/start after the accepting edge has no effect on the operation in flight.
//  Reset mid-operation:
//   - The operation is discarded; no done pulse.
//   - out returns to 0; the next start after reset release is handled normally.
// TESTING
//  1. a=5, b=3 -> done 5 cycles after accept, out=2, busy low in the done cycle.
//  2. a=3, b=5 -> out = p-2 = 2^255-21 (correction path selected).
//  3. a=b=0x1234_5678_9ABC_DEF0 << 128 -> out=0; then a=0, b=p-1 -> out=1.
//  4. a=2^192, b=1 -> out=2^192-1 (borrow ripples across limbs 0..2).
//  5. start held high continuously with a=7, b=2 -> done pulse every 6 cycles, out=5. Inputs changed mid-op are ignored.
//  6. Assert rst during L2 -> out=0, done=0, busy=0 immediately. Next start (a=9, b=4) -> out=5.

Source files
------------

// File: rtl/ffs.sv
// Multi-cycle modular subtractor over GF(2^255-19): one 64-bit limb subtractor
// and one 64-bit limb adder, with the correction adder running one limb behind.
module ffs (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [254:0] a_i,
    input  logic [254:0] b_i,
    output logic [254:0] out,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {IDLE, L0, L1, L2, L3, FIX} state_t;

    localparam logic [255:0] P =
        256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;

    state_t      state;
    logic [63:0] a_r [4];
    logic [63:0] b_r [4];
    logic [63:0] d_r [4];
    logic [63:0] s_r [3];
    logic        bo;
    logic        c;

    logic [1:0]  sub_idx;
    logic [1:0]  add_idx;
    logic        bo_in;
    logic        c_in;
    logic [64:0] sub_res;
    logic [64:0] add_res;
    logic [63:0] p_l;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        sub_idx = 2'd0;
        add_idx = 2'd0;
        case (state)
            L0:      sub_idx = 2'd0;
            L1:      begin sub_idx = 2'd1; add_idx = 2'd0; end
            L2:      begin sub_idx = 2'd2; add_idx = 2'd1; end
            L3:      begin sub_idx = 2'd3; add_idx = 2'd2; end
            FIX:     add_idx = 2'd3;
            default: ;
        endcase
        bo_in   = (state == L0) ? 1'b0 : bo;
        c_in    = (state == L1) ? 1'b0 : c;
        p_l     = P[{add_idx, 6'b0} +: 64];
        sub_res = {1'b0, a_r[sub_idx]} - {1'b0, b_r[sub_idx]} - {64'b0, bo_in};
        add_res = {1'b0, d_r[add_idx]} + {1'b0, p_l} + {64'b0, c_in};
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bo    <= 1'b0;
            c     <= 1'b0;
            // NOTE: the limb arrays are plain flops, so clearing them on reset is cheap and well defined.
            for (int k = 0; k < 4; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                d_r[k] <= '0;
            end
            for (int k = 0; k < 3; k++) s_r[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        {a_r[3], a_r[2], a_r[1], a_r[0]} <= {1'b0, a_i};
                        {b_r[3], b_r[2], b_r[1], b_r[0]} <= {1'b0, b_i};
                        bo    <= 1'b0;
                        c     <= 1'b0;
                        busy  <= 1'b1;
                        state <= L0;
                    end
                end
                L0, L1, L2, L3: begin
                    d_r[sub_idx] <= sub_res[63:0];
                    bo           <= sub_res[64];
                    if (state != L0) c <= add_res[64];
                    case (state)
                        L0:      state <= L1;
                        L1:      begin s_r[0] <= add_res[63:0]; state <= L2; end
                        L2:      begin s_r[1] <= add_res[63:0]; state <= L3; end
                        default: begin s_r[2] <= add_res[63:0]; state <= FIX; end
                    endcase
                end
                FIX: begin
                    // A final borrow means a < b, so the p-corrected sum is the result.
                    if (bo) out <= {add_res[62:0], s_r[2], s_r[1], s_r[0]};
                    else    out <= {d_r[3][62:0], d_r[2], d_r[1], d_r[0]};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ffs.sv
// Directed self-checking bench for the GF(2^255-19) multi-cycle subtractor.
module tb_ffs;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [254:0] a_i;
    logic [254:0] b_i;
    logic [254:0] out;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    localparam logic [254:0] P =
        255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;

    ffs dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_i   (a_i),
        .b_i   (b_i),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [254:0] got, input logic [254:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One operation: accept, scramble inputs, then expect done exactly 5 edges later.
    task automatic run_op(input string tag, input logic [254:0] a, input logic [254:0] b,
                          input logic [254:0] exp);
        int n;
        @(negedge clk);
        a_i = a; b_i = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a_i = ~a; b_i = ~b;
        check({tag, "_busy_accept"}, 255'(busy), 255'd1);
        n = 0;
        while (n < 10 && !done) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 255'(n), 255'd5);
        check({tag, "_busy_done"}, 255'(busy), 255'd0);
        check({tag, "_out"}, out, exp);
    endtask

    initial begin
        int last_done;
        int ndone;
        rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0;
        #12;
        check("rst_out", out, '0);
        check("rst_busy", 255'(busy), 255'd0);
        check("rst_done", 255'(done), 255'd0);
        @(negedge clk); rst = 1'b0;

        run_op("t1", 255'd5, 255'd3, 255'd2);
        @(posedge clk); #1;
        check("t1_done_pulse", 255'(done), 255'd0);
        check("t1_out_held", out, 255'd2);

        run_op("t2", 255'd3, 255'd5,
               255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffeb);
        run_op("t3a", 255'h123456789abcdef000000000000000000000000000000000,
                      255'h123456789abcdef000000000000000000000000000000000, 255'd0);
        run_op("t3b", 255'd0, P - 255'd1, 255'd1);
        run_op("t4", 255'h1000000000000000000000000000000000000000000000000, 255'd1,
               255'hffffffffffffffffffffffffffffffffffffffffffffffff);

        // Start held high: back-to-back operations, inputs glitched mid-flight.
        @(negedge clk);
        a_i = 255'd7; b_i = 255'd2; start = 1'b1;
        last_done = -1; ndone = 0;
        for (int cyc = 0; cyc < 19; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                check("t5_out", out, 255'd5);
                if (last_done >= 0) check("t5_period", 255'(cyc - last_done), 255'd6);
                last_done = cyc;
                ndone++;
            end
            if (cyc % 6 == 1) begin a_i = 255'd100; b_i = 255'd1; end
            if (cyc % 6 == 4) begin a_i = 255'd7;   b_i = 255'd2; end
        end
        check("t5_ndone", 255'(ndone), 255'd3);
        start = 1'b0;
        repeat (8) @(posedge clk);

        // Reset during L2 discards the operation immediately.
        @(negedge clk);
        a_i = 255'd3; b_i = 255'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_out", out, '0);
        check("t6_rst_busy", 255'(busy), 255'd0);
        check("t6_rst_done", 255'(done), 255'd0);
        ndone = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("t6_no_done", 255'(ndone), 255'd0);
        @(negedge clk); rst = 1'b0;
        run_op("t6", 255'd9, 255'd4, 255'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
